// File: rtl/mem_access_unit.sv
// Sequential load/store bridge: serializes 32-bit MIPS data accesses into big-endian
// single-byte memory cycles and returns the assembled, extended load result.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MEMORY_SIZE    = 16384,
  parameter int unsigned ADDRESS_LENGTH = $clog2(MEMORY_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic                      we,
  input  logic [1:0]                size,
  input  logic                      sign_ext,
  input  logic [31:0]               address,
  input  logic [31:0]               data_in,
  output logic                      ready,
  output logic                      done,
  output logic                      err,
  output logic [31:0]               data_out,
  output logic [ADDRESS_LENGTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]     mem_data_in,
  output logic                      mem_we,
  input  logic [DATA_WIDTH-1:0]     mem_data_out
);

  typedef enum logic [1:0] {StIdle, StXfer, StResp} state_e;

  state_e                    state_q, state_d;
  logic                      we_q, we_d;
  logic [1:0]                size_q, size_d;
  logic                      sext_q, sext_d;
  logic [ADDRESS_LENGTH-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [1:0]                k_q, k_d;
  logic                      err_q, err_d;
  logic [31:0]               acc_q, acc_d;
  logic [31:0]               data_out_q, data_out_d;

  logic       req_err;
  logic [1:0] last_k;
  logic [1:0] byte_sel;

  // Range check compares only the bits above the memory address width.
  assign req_err = (size == 2'b11) ||
                   (size == 2'b01 && address[0]) ||
                   (size == 2'b10 && (|address[1:0])) ||
                   (|address[31:ADDRESS_LENGTH]);

  assign last_k   = (size_q == 2'b00) ? 2'd0 : (size_q == 2'b01) ? 2'd1 : 2'd3;
  assign byte_sel = last_k - k_q;
  assign data_out = data_out_q;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                         input logic sx);
    logic [31:0] r;
    unique case (sz)
      2'b00:   r = {{24{sx & v[7]}}, v[7:0]};
      2'b01:   r = {{16{sx & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sext_d      = sext_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    k_d         = k_q;
    err_d       = err_q;
    acc_d       = acc_q;
    data_out_d  = data_out_q;
    ready       = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    mem_we      = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          addr_d  = address[ADDRESS_LENGTH-1:0];
          wdata_d = data_in;
          k_d     = 2'd0;
          acc_d   = '0;
          err_d   = req_err;
          state_d = req_err ? StResp : StXfer;
        end
      end
      StXfer: begin
        mem_address = addr_q + {{(ADDRESS_LENGTH-2){1'b0}}, k_q};
        if (we_q) begin
          mem_we      = 1'b1;
          mem_data_in = wdata_q[DATA_WIDTH*byte_sel +: DATA_WIDTH];
        end else begin
          acc_d = {acc_q[31-DATA_WIDTH:0], mem_data_out};
        end
        k_d = k_q + 2'd1;
        if (k_q == last_k) begin
          state_d = StResp;
          // Result is published on entry to RESP so it is valid alongside done.
          if (!we_q) data_out_d = extend(acc_d, size_q, sext_q);
        end
      end
      StResp: begin
        done    = 1'b1;
        err     = err_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      k_q        <= 2'd0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      k_q        <= k_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a byte-wide memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] address, data_in;
  logic        ready, done, err;
  logic [31:0] data_out;
  logic [13:0] mem_address;
  logic [7:0]  mem_data_in, mem_data_out;
  logic        mem_we;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;

  logic [7:0] mem [0:16383] = '{default: 8'h00};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_address] <= mem_data_in;
      n_wr <= n_wr + 1;
    end
  end
  assign mem_data_out = mem[mem_address];

  mem_access_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .we          (we),
    .size        (size),
    .sign_ext    (sign_ext),
    .address     (address),
    .data_in     (data_in),
    .ready       (ready),
    .done        (done),
    .err         (err),
    .data_out    (data_out),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_we      (mem_we),
    .mem_data_out(mem_data_out)
  );

  // Issues one request, scrambles the inputs after acceptance, and reports the cycle
  // count (1 = cycle right after the accepting edge) at which done is seen; 0 = timeout.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic e, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sx; address = a; data_in = wd;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = ~w; size = 2'b11; sign_ext = ~sx;
    address = 32'hFFFF_FFFF; data_in = 32'h0BAD_0BAD;
    lat = 0; e = 1'bx; d = 32'hx;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      if (done) begin
        lat = c; e = err; d = data_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    if ({ready, done, err, mem_we} !== 4'b1000) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 1000", {ready, done, err, mem_we});
    end
    n_cmp++;
    if (data_out !== 32'h0) begin
      n_bad++; $display("FAIL reset_data_out: got %h want 00000000", data_out);
    end
    n_cmp++;
    if ({mem_address, mem_data_in} !== 22'h0) begin
      n_bad++; $display("FAIL reset_mem_port: addr %h data %h want 0", mem_address, mem_data_in);
    end
    n_cmp++;
  endtask

  task automatic test_word_round_trip();
    int lat; logic e; logic [31:0] d; int w0;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, e, d);
    if (lat !== 5 || e !== 1'b0) begin
      n_bad++; $display("FAIL sw_done: lat %0d err %b want 5 0", lat, e);
    end
    n_cmp++;
    if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL sw_mem: got %h want deadbeef", {mem[16], mem[17], mem[18], mem[19]});
    end
    n_cmp++;
    w0 = n_wr;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, d);
    if (lat !== 5 || e !== 1'b0 || d !== 32'hDEAD_BEEF) begin
      n_bad++; $display("FAIL lw: lat %0d err %b data %h want 5 0 deadbeef", lat, e, d);
    end
    n_cmp++;
    if (n_wr !== w0) begin
      n_bad++; $display("FAIL lw_no_write: writes %0d want %0d", n_wr, w0);
    end
    n_cmp++;
  endtask

  task automatic test_byte_half();
    int lat; logic e; logic [31:0] d;
    logic [1:0]  szs [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sxs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ads [4] = '{32'h21, 32'h21, 32'h22, 32'h22};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};
    int          lts [4] = '{2, 2, 3, 3};
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_5680, lat, e, d);
    if (lat !== 2 || e !== 1'b0 || {mem[32], mem[33]} !== 16'h0080) begin
      n_bad++; $display("FAIL sb: lat %0d err %b mem %h want 2 0 0080", lat, e, {mem[32], mem[33]});
    end
    n_cmp++;
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD_8001, lat, e, d);
    if (lat !== 3 || e !== 1'b0 || {mem[34], mem[35], mem[36]} !== 24'h800100) begin
      n_bad++;
      $display("FAIL sh: lat %0d err %b mem %h want 3 0 800100", lat, e, {mem[34], mem[35], mem[36]});
    end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, szs[i], sxs[i], ads[i], 32'h0, lat, e, d);
      if (lat !== lts[i] || e !== 1'b0 || d !== exp[i]) begin
        n_bad++;
        $display("FAIL load%0d: lat %0d err %b data %h want %0d 0 %h", i, lat, e, d, lts[i], exp[i]);
      end
      n_cmp++;
    end
  endtask

  task automatic test_errors();
    int lat; logic e; logic [31:0] d; int w0;
    logic        wes [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0]  szs [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    logic [31:0] ads [4] = '{32'h2, 32'h3, 32'h8, 32'h4000};
    for (int i = 0; i < 4; i++) begin
      w0 = n_wr;
      do_req(wes[i], szs[i], 1'b1, ads[i], 32'hFFFF_FFFF, lat, e, d);
      if (lat !== 1 || e !== 1'b1 || d !== 32'h0000_8001 || n_wr !== w0) begin
        n_bad++;
        $display("FAIL err%0d: lat %0d err %b data %h writes %0d want 1 1 00008001 %0d",
                 i, lat, e, d, n_wr - w0, 0);
      end
      n_cmp++;
    end
  endtask

  task automatic test_boundary();
    int lat; logic e; logic [31:0] d;
    do_req(1'b1, 2'b10, 1'b0, 32'h3FFC, 32'hCAFE_F00D, lat, e, d);
    if (lat !== 5 || e !== 1'b0 ||
        {mem[16380], mem[16381], mem[16382], mem[16383], mem[0]} !== 40'hCAFE_F00D_00) begin
      n_bad++;
      $display("FAIL bound_sw: lat %0d err %b mem %h want 5 0 cafef00d00", lat, e,
               {mem[16380], mem[16381], mem[16382], mem[16383], mem[0]});
    end
    n_cmp++;
    do_req(1'b0, 2'b10, 1'b0, 32'h3FFC, 32'h0, lat, e, d);
    if (lat !== 5 || e !== 1'b0 || d !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL bound_lw: lat %0d err %b data %h want 5 0 cafef00d", lat, e, d);
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    int n_acc = 0; int d1 = 0; int d2 = 0; int n_done = 0; logic pend = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0;
    address = 32'h40; data_in = 32'h1122_3344;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (pend) begin
        req = 1'b0; we = 1'b0; address = 32'h80; data_in = 32'h0; pend = 1'b0;
      end else if (n_acc == 0) begin
        address = 32'h44; data_in = 32'h5566_7788;
      end
      if (done) begin
        n_done++;
        if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
      end
      if (req && ready) begin
        n_acc++; pend = 1'b1;
      end
    end
    if (n_acc !== 1 || n_done !== 2 || d1 !== 5 || d2 !== 11) begin
      n_bad++;
      $display("FAIL b2b_timing: acc %0d dones %0d d1 %0d d2 %0d want 1 2 5 11",
               n_acc, n_done, d1, d2);
    end
    n_cmp++;
    if ({mem[64], mem[65], mem[66], mem[67], mem[68], mem[69], mem[70], mem[71]} !==
        64'h1122_3344_5566_7788) begin
      n_bad++;
      $display("FAIL b2b_mem: got %h want 1122334455667788",
               {mem[64], mem[65], mem[66], mem[67], mem[68], mem[69], mem[70], mem[71]});
    end
    n_cmp++;
  endtask

  task automatic test_reset_abort();
    int n_done = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0;
    address = 32'h100; data_in = 32'hA1B2_C3D4;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (mem_we !== 1'b1) begin
      n_bad++; $display("FAIL abort_pre: mem_we %b want 1", mem_we);
    end
    n_cmp++;
    rst_n = 1'b0;
    #1;
    if (mem_we !== 1'b0 || ready !== 1'b1 || mem_address !== 14'h0) begin
      n_bad++;
      $display("FAIL abort_async: mem_we %b ready %b addr %h want 0 1 0", mem_we, ready, mem_address);
    end
    n_cmp++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    if (n_done !== 0 || data_out !== 32'h0) begin
      n_bad++; $display("FAIL abort_done: dones %0d data %h want 0 0", n_done, data_out);
    end
    n_cmp++;
    if ({mem[256], mem[257], mem[258], mem[259]} !== 32'hA1B2_0000) begin
      n_bad++;
      $display("FAIL abort_mem: got %h want a1b20000", {mem[256], mem[257], mem[258], mem[259]});
    end
    n_cmp++;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    address = 32'h0; data_in = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_word_round_trip();
    test_byte_half();
    test_errors();
    test_boundary();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
